// File: rtl/parity_frame_ctrl.sv
// -----------------------------------------------------------------------------
// parity_frame_ctrl
//
// Purpose:
//   Takes a parallel data word and its received parity bit through a
//   valid/ready handshake. It shifts the word out LSB-first on ser_bit, with
//   ser_en marking each valid bit, and accumulates running parity one bit at
//   a time, exactly as the downstream serial parity checker does. At the end
//   of the frame the accumulated parity is compared with the received parity
//   bit. The verdict is reported on par_calc / par_err together with a
//   one-cycle done strobe.
//
// Parameters:
//   DATA_W     - data word width in bits (2..32)
//   ODD_PARITY - 0: expected bit = XOR(data), 1: expected bit = ~XOR(data)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   producer has a word
//   in_ready  out  block can accept a word (high only in IDLE)
//   in_data   in   word to serialise / check (sampled at the handshake only)
//   in_par    in   received parity bit for in_data (sampled at the handshake)
//   abort     in   synchronous frame abort (also blocks acceptance in IDLE)
//   ser_bit   out  current serial data bit
//   ser_en    out  ser_bit valid this cycle
//   busy      out  frame in progress (SHIFT or CHECK)
//   done      out  one-cycle verdict strobe (CHECK cycle, not aborted)
//   par_calc  out  expected parity of the last completed frame
//   par_err   out  1 when in_par disagreed with par_calc on that frame
//   err_cnt   out  saturating parity error count (optional feature)
//   err_clr   in   synchronous clear of err_cnt (optional feature)
//
// Build option:
//   PARITY_ERR_COUNT_EN - when defined, err_cnt counts frames that ended
//   with par_err set. The count saturates at 255 and is cleared by err_clr.
//   When undefined, err_cnt is tied to zero and err_clr is ignored.
// -----------------------------------------------------------------------------
module parity_frame_ctrl #(
   parameter int DATA_W     = 8,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_par,
   input  logic              abort,
   output logic              ser_bit,
   output logic              ser_en,
   output logic              busy,
   output logic              done,
   output logic              par_calc,
   output logic              par_err,
   output logic [7:0]        err_cnt,
   input  logic              err_clr
);

   // The counter holds the number of bits still to go after the current one.
   // It therefore only needs to reach DATA_W-1.
   localparam int                CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              acc_q, acc_d;
   logic              par_in_q, par_in_d;
   logic              in_ready_q, in_ready_d;
   logic              busy_q, busy_d;
   logic              ser_en_q, ser_en_d;
   logic              ser_bit_q, ser_bit_d;
   logic              par_calc_q, par_calc_d;
   logic              par_err_q, par_err_d;

   logic              accept;
   logic              verdict_upd;
   logic              verdict_calc;
   logic              verdict_err;

   // in_ready_q is high exactly when the state is IDLE. Using it here keeps
   // the handshake in step with what the producer sees on the port. Abort
   // takes priority over a pending word.
   assign accept       = in_valid && in_ready_q && !abort;

   // An abort that arrives in the CHECK cycle suppresses the verdict. It
   // does this combinationally, so that the done strobe of that cycle is
   // also withheld.
   assign verdict_upd  = (state_q == CHECK) && !abort;
   assign verdict_calc = acc_q ^ ODD_PARITY;
   assign verdict_err  = verdict_calc ^ par_in_q;

   // -------------------------------------------------------------------------
   // Next-state and datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      par_in_d   = par_in_q;
      par_calc_d = par_calc_q;
      par_err_d  = par_err_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_d  = in_data;
               par_in_d = in_par;
               acc_d    = 1'b0;
               cnt_d    = CNT_LOAD;
               state_d  = SHIFT;
            end
         end

         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               acc_d   = acc_q ^ shreg_q[0];
               shreg_d = shreg_q >> 1;
               cnt_d   = cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  state_d = CHECK;
               end
            end
         end

         CHECK: begin
            state_d = IDLE;
            if (verdict_upd) begin
               par_calc_d = verdict_calc;
               par_err_d  = verdict_err;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The port-level status flags are registered. They are computed from the
   // next state, so they change on the same edge as the state register.
   always_comb begin
      in_ready_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
      ser_en_d   = (state_d == SHIFT);
      ser_bit_d  = (state_d == SHIFT) ? shreg_d[0] : 1'b0;
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         cnt_q      <= '0;
         acc_q      <= 1'b0;
         par_in_q   <= 1'b0;
         in_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         ser_en_q   <= 1'b0;
         ser_bit_q  <= 1'b0;
         par_calc_q <= 1'b0;
         par_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         par_in_q   <= par_in_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         ser_en_q   <= ser_en_d;
         ser_bit_q  <= ser_bit_d;
         par_calc_q <= par_calc_d;
         par_err_q  <= par_err_d;
      end
   end

   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign ser_en   = ser_en_q;
   assign ser_bit  = ser_bit_q;
   assign done     = verdict_upd;
   assign par_calc = par_calc_q;
   assign par_err  = par_err_q;

   // -------------------------------------------------------------------------
   // Parity error counter
   // -------------------------------------------------------------------------
`ifdef PARITY_ERR_COUNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // A clear wins over an increment in the same cycle. Aborted frames never
   // reach verdict_upd, so they are never counted.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         err_cnt_d = '0;
      end else if (verdict_upd && verdict_err && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_err_clr;

   assign unused_err_clr = err_clr;
   assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_ctrl
//
// Directed bench for parity_frame_ctrl. It drives one even-parity instance
// and one odd-parity instance from the same stimulus, and checks each
// against hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_parity_frame_ctrl;

`ifdef PARITY_ERR_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_par;
   logic       abort;
   logic       err_clr;

   logic       e_in_ready, e_ser_bit, e_ser_en, e_busy, e_done, e_par_calc, e_par_err;
   logic [7:0] e_err_cnt;
   logic       o_in_ready, o_ser_bit, o_ser_en, o_busy, o_done, o_par_calc, o_par_err;
   logic [7:0] o_err_cnt;

   int n_cmp;
   int n_bad;
   int exp_err_e;

   parity_frame_ctrl #(.DATA_W(8), .ODD_PARITY(1'b0)) u_even (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(e_in_ready),
      .in_data(in_data), .in_par(in_par), .abort(abort), .ser_bit(e_ser_bit),
      .ser_en(e_ser_en), .busy(e_busy), .done(e_done), .par_calc(e_par_calc),
      .par_err(e_par_err), .err_cnt(e_err_cnt), .err_clr(err_clr)
   );

   parity_frame_ctrl #(.DATA_W(8), .ODD_PARITY(1'b1)) u_odd (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_in_ready),
      .in_data(in_data), .in_par(in_par), .abort(abort), .ser_bit(o_ser_bit),
      .ser_en(o_ser_en), .busy(o_busy), .done(o_done), .par_calc(o_par_calc),
      .par_err(o_par_err), .err_cnt(o_err_cnt), .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one frame (the DUT must be idle). It collects the serial stream,
   // records the cycle of done relative to the handshake edge, and samples
   // the verdict on the cycle after done.
   task automatic run_frame(input logic [7:0] d, input logic p, input bit use_odd,
                            output logic [7:0] bits, output int n_en,
                            output int done_at, output logic pc, output logic pe);
      n_en    = 0;
      done_at = -1;
      bits    = '0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_par   = p;
      @(posedge clk);
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 1) in_valid = 1'b0;
         if (use_odd ? o_ser_en : e_ser_en) begin
            if (n_en < 8) bits[n_en] = use_odd ? o_ser_bit : e_ser_bit;
            n_en++;
         end
         if (use_odd ? o_done : e_done) begin
            done_at = c;
            break;
         end
      end
      @(negedge clk);
      pc = use_odd ? o_par_calc : e_par_calc;
      pe = use_odd ? o_par_err : e_par_err;
      $display("frame %s data=%02h par=%b -> bits=%02h en=%0d done@%0d calc=%b err=%b",
               use_odd ? "odd " : "even", d, p, bits, n_en, done_at, pc, pe);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++; if (e_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", e_in_ready); end
      n_cmp++; if (e_ser_en !== 1'b0) begin n_bad++; $display("FAIL reset_ser_en: got %b want 0", e_ser_en); end
      n_cmp++; if (e_ser_bit !== 1'b0) begin n_bad++; $display("FAIL reset_ser_bit: got %b want 0", e_ser_bit); end
      n_cmp++; if (e_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", e_busy); end
      n_cmp++; if (e_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", e_done); end
      n_cmp++; if ({e_par_calc, e_par_err} !== 2'b00) begin n_bad++; $display("FAIL reset_verdict: got %b%b want 00", e_par_calc, e_par_err); end
      n_cmp++; if (e_err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", e_err_cnt); end
      n_cmp++; if (o_in_ready !== 1'b1 || o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_odd: got ready=%b busy=%b want 1/0", o_in_ready, o_busy); end
      $display("reset checked");
   endtask

   task automatic test_basic();
      logic [7:0] bits; int n_en, done_at; logic pc, pe;
      run_frame(8'hA5, 1'b0, 1'b0, bits, n_en, done_at, pc, pe);
      n_cmp++; if (bits !== 8'hA5) begin n_bad++; $display("FAIL a5_stream: got %02h want a5", bits); end
      n_cmp++; if (n_en !== 8) begin n_bad++; $display("FAIL a5_en_cycles: got %0d want 8", n_en); end
      n_cmp++; if (done_at !== 9) begin n_bad++; $display("FAIL a5_done_latency: got %0d want 9", done_at); end
      n_cmp++; if ({pc, pe} !== 2'b00) begin n_bad++; $display("FAIL a5_verdict: got %b%b want 00", pc, pe); end
      n_cmp++; if (e_in_ready !== 1'b1 || e_busy !== 1'b0) begin n_bad++; $display("FAIL a5_idle: got ready=%b busy=%b want 1/0", e_in_ready, e_busy); end
      run_frame(8'h01, 1'b0, 1'b0, bits, n_en, done_at, pc, pe);
      if (CNT_EN) exp_err_e++;
      n_cmp++; if ({pc, pe} !== 2'b11) begin n_bad++; $display("FAIL x01_verdict: got %b%b want 11", pc, pe); end
      n_cmp++; if (bits !== 8'h01) begin n_bad++; $display("FAIL x01_stream: got %02h want 01", bits); end
      n_cmp++; if (e_err_cnt !== 8'(exp_err_e)) begin n_bad++; $display("FAIL x01_err_cnt: got %0d want %0d", e_err_cnt, exp_err_e); end
   endtask

   task automatic test_odd_parity();
      logic [7:0] bits; int n_en, done_at; logic pc, pe;
      run_frame(8'h00, 1'b1, 1'b1, bits, n_en, done_at, pc, pe);
      if (CNT_EN) exp_err_e++;   // even instance sees 00 with par 1
      n_cmp++; if ({pc, pe} !== 2'b10) begin n_bad++; $display("FAIL odd_x00_verdict: got %b%b want 10", pc, pe); end
      n_cmp++; if (e_par_err !== 1'b1) begin n_bad++; $display("FAIL even_x00_par1: got %b want 1", e_par_err); end
      run_frame(8'hFF, 1'b0, 1'b1, bits, n_en, done_at, pc, pe);
      n_cmp++; if ({pc, pe} !== 2'b11) begin n_bad++; $display("FAIL odd_xff_verdict: got %b%b want 11", pc, pe); end
      n_cmp++; if (bits !== 8'hFF || done_at !== 9) begin n_bad++; $display("FAIL odd_xff_stream: got %02h done@%0d want ff done@9", bits, done_at); end
      n_cmp++; if (o_err_cnt !== (CNT_EN ? 8'd2 : 8'd0)) begin n_bad++; $display("FAIL odd_err_cnt: got %0d want %0d", o_err_cnt, CNT_EN ? 2 : 0); end
      n_cmp++; if (e_err_cnt !== 8'(exp_err_e)) begin n_bad++; $display("FAIL even_err_cnt: got %0d want %0d", e_err_cnt, exp_err_e); end
   endtask

   task automatic test_back_to_back();
      int ready_low, first_ready, done_cnt;
      logic pe1, pe2;
      ready_low = 0; first_ready = -1; done_cnt = 0; pe1 = 1'bx; pe2 = 1'bx;
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h03; in_par = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (c == 1) in_data = 8'h07;
         if (first_ready > 0 && c == first_ready + 1) in_valid = 1'b0;
         if (first_ready < 0) begin
            if (!e_in_ready) ready_low++;
            else first_ready = c;
         end
         if (e_done) done_cnt++;
         if (c == 10) pe1 = e_par_err;
         if (c == 20) pe2 = e_par_err;
      end
      if (CNT_EN) exp_err_e++;
      $display("b2b: ready_low=%0d second_accept@%0d dones=%0d err=%b,%b", ready_low, first_ready, done_cnt, pe1, pe2);
      n_cmp++; if (first_ready !== 10) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 10", first_ready); end
      n_cmp++; if (ready_low !== 9) begin n_bad++; $display("FAIL b2b_ready_low: got %0d want 9", ready_low); end
      n_cmp++; if (done_cnt !== 2) begin n_bad++; $display("FAIL b2b_dones: got %0d want 2", done_cnt); end
      n_cmp++; if (pe1 !== 1'b0) begin n_bad++; $display("FAIL b2b_x03_err: got %b want 0", pe1); end
      n_cmp++; if (pe2 !== 1'b1) begin n_bad++; $display("FAIL b2b_x07_err: got %b want 1", pe2); end
   endtask

   task automatic test_abort();
      int saw_done;
      // Abort in the 4th SHIFT cycle of 0x01; prior verdict is calc=1 err=1.
      saw_done = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h01; in_par = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) in_valid = 1'b0;
         if (c == 4) abort = 1'b1;
         if (e_done) saw_done++;
      end
      @(negedge clk);
      abort = 1'b0;
      n_cmp++; if (e_in_ready !== 1'b1 || e_busy !== 1'b0 || e_ser_en !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got ready=%b busy=%b en=%b want 1/0/0", e_in_ready, e_busy, e_ser_en); end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (e_done) saw_done++;
      end
      n_cmp++; if (saw_done !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d dones want 0", saw_done); end
      n_cmp++; if ({e_par_calc, e_par_err} !== 2'b11) begin n_bad++; $display("FAIL abort_verdict_held: got %b%b want 11", e_par_calc, e_par_err); end
      $display("abort in SHIFT: dones=%0d", saw_done);

      // Abort while idle blocks acceptance.
      @(negedge clk);
      in_valid = 1'b1; abort = 1'b1; in_data = 8'h01;
      @(negedge clk);
      in_valid = 1'b0; abort = 1'b0;
      n_cmp++; if (e_busy !== 1'b0 || e_in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_idle_priority: got busy=%b ready=%b want 0/1", e_busy, e_in_ready); end
      $display("abort in IDLE: busy=%b", e_busy);

      // Abort in the CHECK cycle of 0x00/0 withholds done and the verdict.
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h00; in_par = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (c == 1) in_valid = 1'b0;
      end
      n_cmp++; if (e_done !== 1'b1 || e_ser_en !== 1'b0) begin n_bad++; $display("FAIL check_cycle: got done=%b en=%b want 1/0", e_done, e_ser_en); end
      abort = 1'b1;
      #1;
      n_cmp++; if (e_done !== 1'b0) begin n_bad++; $display("FAIL abort_check_done: got %b want 0", e_done); end
      @(negedge clk);
      abort = 1'b0;
      n_cmp++; if ({e_par_calc, e_par_err} !== 2'b11) begin n_bad++; $display("FAIL abort_check_verdict: got %b%b want 11", e_par_calc, e_par_err); end
      n_cmp++; if (e_err_cnt !== 8'(exp_err_e)) begin n_bad++; $display("FAIL abort_err_cnt: got %0d want %0d", e_err_cnt, exp_err_e); end
      $display("abort in CHECK: calc=%b err=%b", e_par_calc, e_par_err);
   endtask

   task automatic test_reset_mid_frame();
      int saw_done;
      saw_done = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hA5; in_par = 1'b0;
      @(posedge clk);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      exp_err_e = 0;
      n_cmp++; if (e_ser_en !== 1'b0 || e_ser_bit !== 1'b0 || e_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_serial: got en=%b bit=%b busy=%b want 000", e_ser_en, e_ser_bit, e_busy); end
      n_cmp++; if (e_in_ready !== 1'b1 || e_done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_hs: got ready=%b done=%b want 1/0", e_in_ready, e_done); end
      n_cmp++; if ({e_par_calc, e_par_err} !== 2'b00 || e_err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_mid_verdict: got %b%b cnt=%0d want 00 cnt=0", e_par_calc, e_par_err, e_err_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (e_done) saw_done++;
      end
      n_cmp++; if (saw_done !== 0 || e_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_discard: got dones=%0d busy=%b want 0/0", saw_done, e_busy); end
      $display("reset mid-frame: dones after=%0d", saw_done);
   endtask

   task automatic test_err_saturation();
      logic [7:0] bits; int n_en, done_at; logic pc, pe;
      for (int i = 0; i < 260; i++) begin
         run_frame(8'h01, 1'b0, 1'b0, bits, n_en, done_at, pc, pe);
         if (i == 254) begin
            n_cmp++; if (e_err_cnt !== (CNT_EN ? 8'd255 : 8'd0)) begin n_bad++; $display("FAIL sat_255: got %0d want %0d", e_err_cnt, CNT_EN ? 255 : 0); end
         end
      end
      n_cmp++; if (e_err_cnt !== (CNT_EN ? 8'd255 : 8'd0)) begin n_bad++; $display("FAIL sat_hold: got %0d want %0d", e_err_cnt, CNT_EN ? 255 : 0); end
   endtask

   task automatic test_err_clear();
      logic [7:0] bits; int n_en, done_at; logic pc, pe;
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h01; in_par = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (c == 1) in_valid = 1'b0;
      end
      err_clr = 1'b1;  // coincides with an erroring CHECK cycle
      @(negedge clk);
      err_clr = 1'b0;
      $display("clear during CHECK: err_cnt=%0d err=%b", e_err_cnt, e_par_err);
      n_cmp++; if (e_err_cnt !== 8'd0) begin n_bad++; $display("FAIL clr_wins: got %0d want 0", e_err_cnt); end
      n_cmp++; if (e_par_err !== 1'b1) begin n_bad++; $display("FAIL clr_par_err: got %b want 1", e_par_err); end
      run_frame(8'h01, 1'b0, 1'b0, bits, n_en, done_at, pc, pe);
      n_cmp++; if (e_err_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin n_bad++; $display("FAIL clr_recount: got %0d want %0d", e_err_cnt, CNT_EN ? 1 : 0); end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; exp_err_e = 0;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_par = 1'b0;
      abort = 1'b0; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_basic();
      test_odd_parity();
      test_back_to_back();
      test_abort();
      test_reset_mid_frame();
      test_err_saturation();
      test_err_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
